// File: rtl/dll_lock_detect.sv
// DLL lock detector: watches the SAR code after the search completes and
// declares lock once it holds steady. Optional LOCK_CODE_AVG_EN (needs LOCK_CNT>=4).
module dll_lock_detect #(
    parameter int LOCK_CNT  = 16,
    parameter int DRIFT_TOL = 2
) (
    input  logic       clk4,
    input  logic       rst,
    input  logic [9:0] Q,
    input  logic [3:0] count,
    output logic       lock,
    output logic [9:0] lock_code,
    output logic [1:0] state,
    output logic       relock_req
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [1:0] LOST   = 2'd3;

    localparam logic [9:0] MID_CODE = 10'b1000000000;

    logic [1:0] state_d, state_q;
    logic       lock_d, lock_q;
    logic [9:0] lock_code_d, lock_code_q;
    logic       relock_d, relock_q;
    logic [7:0] settle_cnt_d, settle_cnt_q;
    logic [9:0] ref_code_d, ref_code_q;
    logic       drift_d, drift_q;

    logic signed [10:0] diff_ref, diff_lock;
    logic [10:0]        abs_ref, abs_lock;
    logic               in_tol_ref, in_tol_lock;
    logic [7:0]         settle_inc;
    logic [9:0]         cap_code;

    // Unsigned codes widened to 11 bits so 0 vs 1023 never wraps.
    assign diff_ref    = $signed({1'b0, Q}) - $signed({1'b0, ref_code_q});
    assign diff_lock   = $signed({1'b0, Q}) - $signed({1'b0, lock_code_q});
    assign abs_ref     = diff_ref[10] ? 11'(-diff_ref) : 11'(diff_ref);
    assign abs_lock    = diff_lock[10] ? 11'(-diff_lock) : 11'(diff_lock);
    assign in_tol_ref  = abs_ref <= 11'(DRIFT_TOL);
    assign in_tol_lock = abs_lock <= 11'(DRIFT_TOL);
    assign settle_inc  = settle_cnt_q + 8'd1;

`ifdef LOCK_CODE_AVG_EN
    logic [3:0][9:0] hist_d, hist_q;
    logic [11:0]     avg_sum;

    // The current Q is the newest of the four averaged samples.
    assign avg_sum  = 12'(Q) + 12'(hist_q[0]) + 12'(hist_q[1])
                    + 12'(hist_q[2]) + 12'd2;
    assign cap_code = avg_sum[11:2];
`else
    assign cap_code = Q;
`endif

    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        lock_code_d  = lock_code_q;
        relock_d     = 1'b0;
        settle_cnt_d = settle_cnt_q;
        ref_code_d   = ref_code_q;
        drift_d      = drift_q;
`ifdef LOCK_CODE_AVG_EN
        hist_d       = hist_q;
`endif
        case (state_q)
            SEARCH: begin
                lock_d = 1'b0;
                if (count == 4'd0) begin
                    ref_code_d   = Q;
                    settle_cnt_d = 8'd0;
                    state_d      = SETTLE;
`ifdef LOCK_CODE_AVG_EN
                    hist_d       = '0;
`endif
                end
            end
            SETTLE: begin
`ifdef LOCK_CODE_AVG_EN
                hist_d = {hist_q[2:0], Q};
`endif
                if (count != 4'd0) begin
                    settle_cnt_d = 8'd0;
                    state_d      = SEARCH;
                end else if (in_tol_ref) begin
                    settle_cnt_d = settle_inc;
                    if (settle_inc == 8'(LOCK_CNT)) begin
                        state_d     = LOCKED;
                        lock_d      = 1'b1;
                        lock_code_d = cap_code;
                        drift_d     = 1'b0;
                    end
                end else begin
                    ref_code_d   = Q;
                    settle_cnt_d = 8'd0;
                end
            end
            LOCKED: begin
                // SAR restart wins over the drift check.
                if (count != 4'd0) begin
                    state_d = SEARCH;
                    lock_d  = 1'b0;
                    drift_d = 1'b0;
                end else if (!in_tol_lock) begin
                    if (drift_q) begin
                        state_d  = LOST;
                        lock_d   = 1'b0;
                        relock_d = 1'b1;
                        drift_d  = 1'b0;
                    end else begin
                        drift_d = 1'b1;
                    end
                end else begin
                    drift_d = 1'b0;
                end
            end
            LOST: begin
                lock_d  = 1'b0;
                state_d = SEARCH;
            end
            default: begin
                lock_d  = 1'b0;
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk4 or posedge rst) begin
        if (rst) begin
            state_q      <= SEARCH;
            lock_q       <= 1'b0;
            lock_code_q  <= MID_CODE;
            relock_q     <= 1'b0;
            settle_cnt_q <= 8'd0;
            ref_code_q   <= MID_CODE;
            drift_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            lock_code_q  <= lock_code_d;
            relock_q     <= relock_d;
            settle_cnt_q <= settle_cnt_d;
            ref_code_q   <= ref_code_d;
            drift_q      <= drift_d;
        end
    end

`ifdef LOCK_CODE_AVG_EN
    always_ff @(posedge clk4 or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end
`endif

    assign lock       = lock_q;
    assign lock_code  = lock_code_q;
    assign state      = state_q;
    assign relock_req = relock_q;

endmodule

// File: tb/tb_dll_lock_detect.sv
// Directed bench for dll_lock_detect: table of LOCKED-drift vectors plus
// hand-written lock-latency, restart, no-wrap and async-reset sequences.
module tb_dll_lock_detect;

    logic       clk4;
    logic       rst;
    logic [9:0] Q;
    logic [3:0] count;
    logic       lock;
    logic [9:0] lock_code;
    logic [1:0] state;
    logic       relock_req;

    int checks;
    int failures;

    dll_lock_detect dut (
        .clk4      (clk4),
        .rst       (rst),
        .Q         (Q),
        .count     (count),
        .lock      (lock),
        .lock_code (lock_code),
        .state     (state),
        .relock_req(relock_req)
    );

    initial clk4 = 1'b0;
    always #5 clk4 = ~clk4;

    typedef struct {
        logic [9:0] q;
        logic [3:0] cnt;
        logic       lk;
        logic [1:0] st;
        logic       rr;
        logic [9:0] code;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge, like the SAR; outputs are
    // sampled 1 time unit after the rising edge.
    task automatic cyc(input logic [9:0] q, input logic [3:0] c);
        @(negedge clk4);
        Q     = q;
        count = c;
        @(posedge clk4);
        #1;
    endtask

    task automatic lock_run(input logic [9:0] q);
        cyc(q, 4'd9);
        for (int n = 1; n <= 17; n++) cyc(q, 4'd0);
        check("lock_run_lock", 32'(lock), 32'd1);
        check("lock_run_state", 32'(state), 32'd2);
    endtask

    initial begin
        logic [9:0] qv;
        logic [9:0] tail[4];

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        Q        = 10'd0;
        count    = 4'd9;

        tbl[0] = '{10'd306, 4'd0, 1'b1, 2'd2, 1'b0, 10'd300};
        tbl[1] = '{10'd300, 4'd0, 1'b1, 2'd2, 1'b0, 10'd300};
        tbl[2] = '{10'd306, 4'd0, 1'b1, 2'd2, 1'b0, 10'd300};
        tbl[3] = '{10'd306, 4'd0, 1'b0, 2'd3, 1'b1, 10'd300};
        tbl[4] = '{10'd306, 4'd0, 1'b0, 2'd0, 1'b0, 10'd300};
        tbl[5] = '{10'd306, 4'd0, 1'b0, 2'd1, 1'b0, 10'd300};
        tbl[6] = '{10'd306, 4'd9, 1'b0, 2'd0, 1'b0, 10'd300};

        tail[0] = 10'd300;
        tail[1] = 10'd301;
        tail[2] = 10'd302;
        tail[3] = 10'd301;

        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_code", 32'(lock_code), 32'd512);
        check("rst_relock", 32'(relock_req), 32'd0);
        @(negedge clk4);
        rst = 1'b0;

        // Search still running, then Q steady at 300.
        cyc(10'd300, 4'd9);
        cyc(10'd300, 4'd9);
        check("search_hold", 32'(state), 32'd0);
        // Edge n=1 is the one that first samples count==0.
        for (int n = 1; n <= 17; n++) begin
            cyc(10'd300, 4'd0);
            if (n == 1) check("settle_entry", 32'(state), 32'd1);
            check($sformatf("lat_lock_e%0d", n), 32'(lock),
                  32'(n == 17));
        end
        check("lat_code", 32'(lock_code), 32'd300);
        check("lat_state", 32'(state), 32'd2);

        // Drift tolerance while LOCKED, loss of lock, and return to search.
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].q, tbl[i].cnt);
            check($sformatf("tbl%0d_lock", i), 32'(lock), 32'(tbl[i].lk));
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("tbl%0d_relock", i), 32'(relock_req),
                  32'(tbl[i].rr));
            check($sformatf("tbl%0d_code", i), 32'(lock_code),
                  32'(tbl[i].code));
        end

        // SAR restart while LOCKED beats a simultaneous big drift.
        lock_run(10'd300);
        cyc(10'd500, 4'd9);
        check("restart_state", 32'(state), 32'd0);
        check("restart_lock", 32'(lock), 32'd0);
        check("restart_relock", 32'(relock_req), 32'd0);
        cyc(10'd500, 4'd9);
        check("restart_relock2", 32'(relock_req), 32'd0);
        check("restart_code", 32'(lock_code), 32'd300);

        // Jittering Q within tolerance still locks; tail feeds the average.
        for (int n = 1; n <= 17; n++) begin
            qv = (n >= 14) ? tail[n-14] : 10'(300 + (n % 3));
            cyc(qv, 4'd0);
            if (n >= 15) check($sformatf("jit_lock_e%0d", n), 32'(lock),
                               32'(n == 17));
        end
        check("jit_code", 32'(lock_code), 32'd301);

        // Jump to 310 on edge 8 restarts the settle count from 310.
        cyc(10'd300, 4'd9);
        check("jump_search", 32'(state), 32'd0);
        for (int n = 1; n <= 24; n++) begin
            if (n == 1) qv = 10'd300;
            else if (n < 8) qv = 10'(300 + (n % 3));
            else qv = 10'd310;
            cyc(qv, 4'd0);
            if (n == 17 || n >= 22)
                check($sformatf("jump_lock_e%0d", n), 32'(lock),
                      32'(n == 24));
        end
        check("jump_code", 32'(lock_code), 32'd310);

        // 0 vs 1023 is a distance of 1023, not 1.
        lock_run(10'd0);
        check("wrap_code", 32'(lock_code), 32'd0);
        cyc(10'd1023, 4'd0);
        check("wrap_first", 32'(lock), 32'd1);
        cyc(10'd1023, 4'd0);
        check("wrap_lost", 32'(state), 32'd3);
        check("wrap_relock", 32'(relock_req), 32'd1);
        cyc(10'd1023, 4'd0);
        check("wrap_search", 32'(state), 32'd0);
        check("wrap_relock_end", 32'(relock_req), 32'd0);

        // Async reset between edges while LOCKED.
        lock_run(10'd300);
        @(negedge clk4);
        #2 rst = 1'b1;
        #1;
        check("arst_lock", 32'(lock), 32'd0);
        check("arst_code", 32'(lock_code), 32'd512);
        check("arst_state", 32'(state), 32'd0);
        check("arst_relock", 32'(relock_req), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk4);
        #1;
        check("arst_resume", 32'(state), 32'd1);
        check("arst_relock2", 32'(relock_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
